// File: rtl/uart_rx_oversampled.sv
// 8N1 UART receiver: 2-flop synchronised line, oversampled start validation, mid-bit data/stop sampling.
// Latency: rx_valid rises 1 clk after the stop-bit sample tick (OVERSAMPLE/2 + 9*OVERSAMPLE ticks after start detect).
// Backpressure: 1-entry holding register; a new byte overwrites an unaccepted one and sets sticky overrun.
module uart_rx_oversampled #(
  parameter int clk_freq   = 1000000,
  parameter int baud_rate  = 9600,
  parameter int OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  localparam int DIV_RAW = clk_freq / (baud_rate * OVERSAMPLE);
  localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam int DW      = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int TW      = $clog2(OVERSAMPLE);

  localparam logic [DW-1:0] DIV_LAST  = DW'(DIV - 1);
  localparam logic [TW-1:0] HALF_LAST = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] BIT_LAST  = TW'(OVERSAMPLE - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_t;

  logic          rx_meta;
  logic          rx_s;
  logic [DW-1:0] div_cnt;
  logic          tick;
  state_t        state;
  logic [TW-1:0] tcnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
  logic          done;

  // Two-flop synchroniser; resets to the idle-high line level.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  // Free-running oversample tick divider; only reset clears it, never the FSM.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_cnt <= '0;
    end else if (tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + DW'(1);
    end
  end

  assign tick = (div_cnt == DIV_LAST);

  // Stop bit is being sampled this cycle; the byte is complete.
  assign done = tick && (state == S_STOP) && (tcnt == BIT_LAST);

  assign busy = (state != S_IDLE);

  // Frame FSM: start validation at half bit, then one sample per bit centre.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= S_IDLE;
      tcnt    <= '0;
      bit_idx <= '0;
      shreg   <= '0;
    end else if (tick) begin
      case (state)
        S_IDLE: begin
          if (!rx_s) begin
            state <= S_START;
            tcnt  <= '0;
          end
        end
        S_START: begin
          if (tcnt == HALF_LAST) begin
            tcnt <= '0;
            if (!rx_s) begin
              state   <= S_DATA;
              bit_idx <= '0;
            end else begin
              // Low pulse shorter than half a bit: treat as a glitch.
              state <= S_IDLE;
            end
          end else begin
            tcnt <= tcnt + TW'(1);
          end
        end
        S_DATA: begin
          if (tcnt == BIT_LAST) begin
            tcnt    <= '0;
            shreg   <= {rx_s, shreg[7:1]};
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) begin
              state <= S_STOP;
            end
          end else begin
            tcnt <= tcnt + TW'(1);
          end
        end
        S_STOP: begin
          if (tcnt == BIT_LAST) begin
            tcnt  <= '0;
            // A low stop bit means the line may be in break; wait for it to return high.
            state <= rx_s ? S_IDLE : S_BREAK;
          end else begin
            tcnt <= tcnt + TW'(1);
          end
        end
        S_BREAK: begin
          if (rx_s) begin
            state <= S_IDLE;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // Holding register with valid/ready handshake and sticky overrun.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else if (done) begin
      rx_data   <= shreg;
      frame_err <= ~rx_s;
      rx_valid  <= 1'b1;
      // Old byte lost only if it was not accepted in this same cycle.
      if (rx_valid && !rx_ready) begin
        overrun <= 1'b1;
      end
    end else if (rx_valid && rx_ready) begin
      rx_valid <= 1'b0;
      overrun  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_rx_oversampled.sv
// Directed bench for uart_rx_oversampled at 16 clk per bit (DIV=1).
// Table of frames checked in a loop, plus hand sequences for glitch, latency, overrun, streaming and reset.
// Line driven just after posedge, outputs sampled on negedge.
module tb_uart_rx_oversampled;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  uart_rx_oversampled #(
    .clk_freq  (1600000),
    .baud_rate (100000),
    .OVERSAMPLE(16)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .rx       (rx),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready),
    .frame_err(frame_err),
    .overrun  (overrun),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Cycle counter and rx_valid monitor (only these processes write these).
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int         rises    = 0;
  int         vcyc     = 0;
  int         rise_cyc = 0;
  logic       prev_v   = 1'b0;
  logic [7:0] rdq[$];
  always @(negedge clk) begin
    if (rx_valid) vcyc++;
    if (rx_valid && !prev_v) begin
      rises++;
      rise_cyc = cyc;
      rdq.push_back(rx_data);
    end
    prev_v = rx_valid;
  end

  int start_cyc = 0;

  typedef struct {
    logic [7:0] dat;
    logic       stop;
    logic [7:0] exp_dat;
    logic       exp_ferr;
    logic       exp_busy;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive_bit(input logic v, input int n);
    rx = v;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Start bit, 8 data bits LSB first, stop level held for stop_len clks (left on the line).
  task automatic send_frame(input logic [7:0] d, input logic stop, input int stop_len);
    @(posedge clk);
    #1;
    start_cyc = cyc;
    drive_bit(1'b0, 16);
    for (int i = 0; i < 8; i++) drive_bit(d[i], 16);
    drive_bit(stop, stop_len);
  endtask

  task automatic accept();
    @(posedge clk);
    #1;
    rx_ready = 1'b1;
    @(posedge clk);
    #1;
    rx_ready = 1'b0;
  endtask

  initial begin
    int base_r;
    int base_v;
    int base_q;
    int hold;

    vecs[0] = '{8'hA5, 1'b1, 8'hA5, 1'b0, 1'b0};
    vecs[1] = '{8'h3C, 1'b0, 8'h3C, 1'b1, 1'b1};
    vecs[2] = '{8'h81, 1'b1, 8'h81, 1'b0, 1'b0};
    vecs[3] = '{8'h5A, 1'b1, 8'h5A, 1'b0, 1'b0};
    vecs[4] = '{8'h01, 1'b1, 8'h01, 1'b0, 1'b0};

    rst      = 1'b0;
    rx       = 1'b1;
    rx_ready = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst_rx_valid", rx_valid, 0);
    check("rst_rx_data", rx_data, 0);
    check("rst_frame_err", frame_err, 0);
    check("rst_overrun", overrun, 0);
    check("rst_busy", busy, 0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (20) @(posedge clk);
    #1;

    // Table-driven frames, each accepted after checking
    for (int i = 0; i < 5; i++) begin
      hold = vecs[i].stop ? 16 : 56;
      send_frame(vecs[i].dat, vecs[i].stop, hold);
      @(negedge clk);
      check($sformatf("vec%0d_valid", i), rx_valid, 1);
      check($sformatf("vec%0d_data", i), rx_data, vecs[i].exp_dat);
      check($sformatf("vec%0d_ferr", i), frame_err, vecs[i].exp_ferr);
      check($sformatf("vec%0d_busy", i), busy, vecs[i].exp_busy);
      @(posedge clk);
      #1;
      rx = 1'b1;
      repeat (8) @(posedge clk);
      @(negedge clk);
      check($sformatf("vec%0d_busy_after", i), busy, 0);
      check($sformatf("vec%0d_overrun", i), overrun, 0);
      accept();
      @(negedge clk);
      check($sformatf("vec%0d_valid_after_acc", i), rx_valid, 0);
      check($sformatf("vec%0d_data_retained", i), rx_data, vecs[i].exp_dat);
    end

    // Latency from start edge and holding with rx_ready low
    base_r = rises;
    send_frame(8'hA5, 1'b1, 16);
    check("lat_rises", rises - base_r, 1);
    check("lat_cycles", rise_cyc - start_cyc, 155);
    repeat (30) @(posedge clk);
    @(negedge clk);
    check("lat_hold_valid", rx_valid, 1);
    check("lat_hold_data", rx_data, 8'hA5);
    accept();

    // Short low glitch in IDLE
    @(posedge clk);
    #1;
    base_r = rises;
    drive_bit(1'b0, 5);
    rx = 1'b1;
    @(negedge clk);
    check("glitch_busy_high", busy, 1);
    repeat (20) @(posedge clk);
    @(negedge clk);
    check("glitch_busy_low", busy, 0);
    check("glitch_no_valid", rises - base_r, 0);
    send_frame(8'h3C, 1'b1, 16);
    @(negedge clk);
    check("glitch_next_valid", rx_valid, 1);
    check("glitch_next_data", rx_data, 8'h3C);
    check("glitch_next_ferr", frame_err, 0);
    accept();

    // Back-to-back with no consumer: overrun
    send_frame(8'h11, 1'b1, 16);
    send_frame(8'h22, 1'b1, 16);
    @(negedge clk);
    check("ovr_valid", rx_valid, 1);
    check("ovr_data", rx_data, 8'h22);
    check("ovr_flag", overrun, 1);
    accept();
    @(negedge clk);
    check("ovr_valid_cleared", rx_valid, 0);
    check("ovr_flag_cleared", overrun, 0);

    // Streaming with rx_ready tied high
    @(posedge clk);
    #1;
    rx_ready = 1'b1;
    base_r = rises;
    base_v = vcyc;
    base_q = rdq.size();
    send_frame(8'h00, 1'b1, 16);
    send_frame(8'hFF, 1'b1, 16);
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("stream_rises", rises - base_r, 2);
    check("stream_valid_cycles", vcyc - base_v, 2);
    check("stream_q_size", rdq.size() - base_q, 2);
    if (rdq.size() - base_q == 2) begin
      check("stream_byte0", rdq[base_q], 8'h00);
      check("stream_byte1", rdq[base_q+1], 8'hFF);
    end
    check("stream_overrun", overrun, 0);
    check("stream_valid_low", rx_valid, 0);
    @(posedge clk);
    #1;
    rx_ready = 1'b0;

    // Reset asserted during data bit 4 with a byte held and overrun set
    send_frame(8'hC3, 1'b1, 16);
    send_frame(8'h99, 1'b1, 16);
    @(negedge clk);
    check("mid_rst_pre_overrun", overrun, 1);
    @(posedge clk);
    #1;
    drive_bit(1'b0, 16);
    for (int i = 0; i < 4; i++) drive_bit(1'b0, 16);
    drive_bit(1'b1, 8);
    check("mid_rst_pre_busy", busy, 1);
    rst = 1'b0;
    #2;
    check("mid_rst_valid", rx_valid, 0);
    check("mid_rst_data", rx_data, 0);
    check("mid_rst_ferr", frame_err, 0);
    check("mid_rst_overrun", overrun, 0);
    check("mid_rst_busy", busy, 0);
    rx = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (40) @(posedge clk);
    @(negedge clk);
    check("post_rst_no_valid", rx_valid, 0);
    send_frame(8'h5A, 1'b1, 16);
    @(negedge clk);
    check("post_rst_valid", rx_valid, 1);
    check("post_rst_data", rx_data, 8'h5A);
    check("post_rst_ferr", frame_err, 0);
    check("post_rst_overrun", overrun, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
